// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage; one 8-byte line buffer split into two
//            little-endian 32-bit instructions, with redirect/flush support.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [63:0] c_reset_pc = RESET_PC & ~64'h3;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] buf_q, buf_d;
    logic        drop_q, drop_d;

    logic [63:0] w_pc_inc;
    logic [63:0] w_redirect_target;
    logic        w_in_req;
    logic        w_in_drain;

    assign w_pc_inc          = pc_q + 64'd4;
    assign w_redirect_target = redirect_pc & ~64'h3;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        drop_d  = drop_q;

        case (state_q)
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        buf_d   = mem_resp_data;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (instr_ready) begin
                    pc_d = w_pc_inc;
                    if (pc_q[2]) begin
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // A redirect overrides everything; an accepted-but-unreturned request
        // still owes us a response, which the drop flag swallows.
        if (redirect_valid) begin
            pc_d  = w_redirect_target;
            buf_d = buf_q;
            case (state_q)
                ST_REQ: begin
                    state_d = mem_req_ready ? ST_WAIT : ST_REQ;
                    drop_d  = mem_req_ready;
                end
                ST_WAIT: begin
                    state_d = mem_resp_valid ? ST_REQ : ST_WAIT;
                    drop_d  = ~mem_resp_valid;
                end
                default: begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= c_reset_pc;
            buf_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs are quiet while reset is held, even once state has settled.
    assign w_in_req   = (state_q == ST_REQ) && !reset;
    assign w_in_drain = (state_q == ST_DRAIN) && !reset;

    assign mem_req_valid = w_in_req;
    assign mem_req_addr  = {pc_q[63:3], 3'b000};
    assign instr_valid   = w_in_drain;
    assign instr         = w_in_drain ? (pc_q[2] ? buf_q[63:32] : buf_q[31:0]) : 32'h0;
    assign instr_pc      = w_in_drain ? pc_q : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Vector table, directed corner sequences and randomized
//            scoreboard bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    fetch_unit #(.RESET_PC(64'h1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rspv;
        logic [63:0] rspd;
        logic        irdy;
        logic        redv;
        logic [63:0] redpc;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [63:0] e_ipc;
    } vec_t;

    int          n_vec;
    int          n_bad;
    int          idle;
    int          n_instr;
    int          pend_cnt;
    bit          pend;
    bit          prev_redir;
    logic [63:0] pend_addr;
    logic [63:0] exp_pc;
    logic [31:0] r;
    vec_t        tbl [20];

    function automatic vec_t v(input logic rst, input logic rdy, input logic rspv,
                               input logic [63:0] rspd, input logic irdy, input logic redv,
                               input logic [63:0] redpc, input logic e_rv, input logic [63:0] e_addr,
                               input logic e_iv, input logic [31:0] e_instr, input logic [63:0] e_ipc);
        vec_t t;
        t.rst = rst;   t.rdy = rdy;     t.rspv = rspv; t.rspd = rspd;
        t.irdy = irdy; t.redv = redv;   t.redpc = redpc;
        t.e_rv = e_rv; t.e_addr = e_addr; t.e_iv = e_iv;
        t.e_instr = e_instr; t.e_ipc = e_ipc;
        return t;
    endfunction

    // Memory image: distinct word for every 4-byte address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        reset          = t.rst;
        mem_req_ready  = t.rdy;
        mem_resp_valid = t.rspv;
        mem_resp_data  = t.rspd;
        instr_ready    = t.irdy;
        redirect_valid = t.redv;
        redirect_pc    = t.redpc;
        @(negedge clk);
        chk("req_valid", 64'(mem_req_valid), 64'(t.e_rv));
        if (t.e_rv) chk("req_addr", mem_req_addr, t.e_addr);
        chk("instr_valid", 64'(instr_valid), 64'(t.e_iv));
        if (t.e_iv || t.rst) begin
            chk("instr", 64'(instr), 64'(t.e_instr));
            chk("instr_pc", instr_pc, t.e_ipc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_bad = 0;
        reset = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset, basic line, redirect in DRAIN, redirect in WAIT with late response.
        tbl[0]  = v(1,0,0,0,0,0,0,            0,0,0,0,0);
        tbl[1]  = v(1,0,0,0,0,0,0,            0,0,0,0,0);
        tbl[2]  = v(0,1,0,0,0,0,0,            1,64'h1000,0,0,0);
        tbl[3]  = v(0,0,1,64'hAAAA_AAAA_BBBB_BBBB,0,0,0, 0,0,0,0,0);
        tbl[4]  = v(0,0,0,0,1,0,0,            0,0,1,32'hBBBB_BBBB,64'h1000);
        tbl[5]  = v(0,0,0,0,1,0,0,            0,0,1,32'hAAAA_AAAA,64'h1004);
        tbl[6]  = v(0,0,0,0,0,0,0,            1,64'h1008,0,0,0);
        tbl[7]  = v(0,1,0,0,0,0,0,            1,64'h1008,0,0,0);
        tbl[8]  = v(0,0,1,64'h1111_1111_2222_2222,0,0,0, 0,0,0,0,0);
        tbl[9]  = v(0,0,0,0,0,0,0,            0,0,1,32'h2222_2222,64'h1008);
        tbl[10] = v(0,0,0,0,0,1,64'h2004,     0,0,1,32'h2222_2222,64'h1008);
        tbl[11] = v(0,1,0,0,0,0,0,            1,64'h2000,0,0,0);
        tbl[12] = v(0,0,1,64'h4444_4444_3333_3333,0,0,0, 0,0,0,0,0);
        tbl[13] = v(0,0,0,0,1,0,0,            0,0,1,32'h4444_4444,64'h2004);
        tbl[14] = v(0,1,0,0,0,0,0,            1,64'h2008,0,0,0);
        tbl[15] = v(0,0,0,0,0,1,64'h3000,     0,0,0,0,0);
        tbl[16] = v(0,0,0,0,0,0,0,            0,0,0,0,0);
        tbl[17] = v(0,0,0,0,0,0,0,            0,0,0,0,0);
        tbl[18] = v(0,0,1,64'hDEAD_BEEF_DEAD_BEEF,0,0,0, 0,0,0,0,0);
        tbl[19] = v(0,0,0,0,0,0,0,            1,64'h3000,0,0,0);
        for (int i = 0; i < 20; i++) apply(tbl[i]);

        // Request held off for 4 cycles, then decoder stalls 5 cycles.
        for (int i = 0; i < 4; i++) apply(v(0,0,0,0,0,0,0, 1,64'h3000,0,0,0));
        apply(v(0,1,0,0,0,0,0, 1,64'h3000,0,0,0));
        apply(v(0,0,1,64'h6666_6666_5555_5555,0,0,0, 0,0,0,0,0));
        for (int i = 0; i < 5; i++) apply(v(0,0,0,0,0,0,0, 0,0,1,32'h5555_5555,64'h3000));
        apply(v(0,0,0,0,1,0,0, 0,0,1,32'h5555_5555,64'h3000));
        apply(v(0,0,0,0,1,0,0, 0,0,1,32'h6666_6666,64'h3004));

        // Redirect near the top of the address space; low bits ignored, pc wraps.
        apply(v(0,0,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFF, 1,64'h3008,0,0,0));
        apply(v(0,1,0,0,0,0,0, 1,64'hFFFF_FFFF_FFFF_FFF8,0,0,0));
        apply(v(0,0,1,64'h7777_7777_8888_8888,0,0,0, 0,0,0,0,0));
        apply(v(0,0,0,0,1,0,0, 0,0,1,32'h7777_7777,64'hFFFF_FFFF_FFFF_FFFC));
        apply(v(0,0,0,0,0,0,0, 1,64'h0,0,0,0));

        // Randomized traffic against an instruction-stream scoreboard.
        apply(v(1,0,0,0,0,0,0, 0,0,0,0,0));
        exp_pc = 64'h1000; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
        prev_redir = 1'b0; idle = 0; n_instr = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset          = 1'b0;
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            r = $urandom;
            case (r[1:0])
                2'd0:    redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, r[7:4]};
                2'd1:    redirect_pc = {48'h0, r[31:16]};
                default: redirect_pc = {$urandom, $urandom};
            endcase
            mem_resp_valid = 1'b0;
            mem_resp_data  = {$urandom, $urandom};
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = {mem_word(pend_addr + 64'd4), mem_word(pend_addr)};
                    pend = 1'b0;
                end
            end
            @(negedge clk);
            chk("req_and_instr_overlap", 64'(mem_req_valid && instr_valid), 64'h0);
            if (prev_redir) chk("instr_valid_after_redirect", 64'(instr_valid), 64'h0);
            if (mem_req_valid) chk("rand_req_addr", mem_req_addr, {exp_pc[63:3], 3'b000});
            if (instr_valid) begin
                chk("rand_instr_pc", instr_pc, exp_pc);
                chk("rand_instr", 64'(instr), 64'(mem_word(exp_pc)));
            end
            if (mem_req_valid && mem_req_ready) begin
                chk("one_outstanding", 64'(pend || mem_resp_valid), 64'h0);
                pend      = 1'b1;
                pend_addr = mem_req_addr;
                pend_cnt  = $urandom_range(1, 4);
            end
            if ((mem_req_valid && mem_req_ready) || mem_resp_valid || (instr_valid && instr_ready))
                idle = 0;
            else
                idle++;
            if (instr_valid && instr_ready) n_instr++;
            if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
            else if (instr_valid && instr_ready) exp_pc = exp_pc + 64'd4;
            prev_redir = redirect_valid;
            if (idle > 40) begin
                chk("watchdog_idle_cycles", 64'(idle), 64'h0);
                break;
            end
        end
        chk("throughput_over_100", 64'(n_instr > 100), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the 32-bit instruction stream consumed by the decoder. It holds the PC and issues 8-byte-aligned reads to the instruction memory port, buffering one 64-bit response. It splits that response into up to two little-endian 32-bit instructions and presents them, with their PCs, over a valid/ready handshake. A redirect input flushes the buffer and restarts fetch at a new PC, including discarding any in-flight response.

## Interface
- RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req_valid  output  1  read request valid.
- mem_req_addr  output  64  request address, always {pc[63:3], 3'b000}.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_resp_valid  input  1  read data valid (exactly one per accepted request, ≥1 cycle after acceptance).
- mem_resp_data  input  64  read data; bits [31:0] = addr+0, [63:32] = addr+4.
- instr_valid  output  1  instr/instr_pc valid toward decoder.
- instr  output  32  instruction.
- instr_pc  output  64  address of instr.
- instr_ready  input  1  decoder consumes instr this cycle.
- redirect_valid  input  1  restart fetch (branch/jump/trap).
- redirect_pc  input  64  new PC; bits [1:0] ignored (treated as 0).

## Operation
- State: pc (64), line buffer (64), FSM {REQ, WAIT, DRAIN}, drop flag (1).
- REQ: mem_req_valid=1. On mem_req_ready → WAIT.
- WAIT: on mem_resp_valid: if drop=1, clear drop and → REQ (data discarded); else capture data into buffer → DRAIN.
- DRAIN: instr_valid=1; instr = pc[2] ? buffer[63:32] : buffer[31:0]; instr_pc = pc. On instr_valid && instr_ready: pc ← pc+4; if old pc[2]=1 → REQ, else stay in DRAIN (second half).
- Entry with pc[2]=1 (misaligned to line) fetches the line and presents only the upper half.
- pc arithmetic is modulo 2^64; pc+4 from 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Redirect (highest priority, any state): pc ← {redirect_pc[63:2],2'b00}; buffer invalid; next state REQ. If redirect occurs in WAIT without a same-cycle mem_resp_valid, set drop=1 and go to WAIT-drop path: remain WAIT until response, discard it, then REQ. If redirect coincides with mem_resp_valid in WAIT, the response is discarded and state → REQ, drop stays 0.
- Redirect in REQ coinciding with mem_req_ready: request counts as accepted; drop=1, state WAIT.
- Redirect coinciding with instr handshake: handshake is complete for the decoder; pc update from redirect wins.
- drop=1 while in REQ is impossible; at most one request outstanding.
- No request issued while in DRAIN (no prefetch).

## Timing
- Reset: pc=RESET_PC, state REQ, drop=0, buffer=0; during the reset cycle mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0. mem_req_valid rises the first cycle after reset deasserts.
- Request accepted at edge T; response at cycle T+k (k≥1); instr_valid asserts at cycle T+k+1.
- Back-to-back consumption: two instructions per line in consecutive cycles when instr_ready=1; then 1 cycle REQ minimum before the next request handshake.
- instr, instr_pc stable while instr_valid=1 and instr_ready=0.
- Redirect at edge R: mem_req_valid=1 at R+1 (unless a response must be dropped first); instr_valid=0 from R+1 until new data returns.
- Reset mid-operation: any in-flight response arriving after reset is ignored only if it arrives during REQ (mem_resp_valid is ignored outside WAIT); memory must not return responses to pre-reset requests after reset.

## Test plan
- Reset RESET_PC=64'h1000, mem_req_ready=1, response 64'hAAAA_AAAA_BBBB_BBBB one cycle later, instr_ready=1 → mem_req_addr=64'h1000; instr 32'hBBBB_BBBB @64'h1000, then 32'hAAAA_AAAA @64'h1004, next request addr 64'h1008.
- Redirect to 64'h2004 while in DRAIN → request addr 64'h2000, only upper half presented with instr_pc=64'h2004, next request 64'h2008.
- Redirect to 64'h3000 in WAIT, response 64'hDEAD_BEEF_DEAD_BEEF arrives 3 cycles later → response discarded, instr_valid stays 0, new request addr 64'h3000.
- instr_ready held 0 for 5 cycles in DRAIN → instr/instr_pc stable, no new mem_req_valid; release → advance normally.
- mem_req_ready held 0 for 4 cycles → mem_req_valid and mem_req_addr held constant until accepted.
- redirect_pc=64'hFFFF_FFFF_FFFF_FFFC, consume one instruction → next request addr 64'h0 (wrap).
